// File: rtl/micro_sequencer.sv
// micro_sequencer: horizontal microcode sequencer with a writable microstore,
// an opcode dispatch table and a small micro-return stack.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   stall                       hold all sequencer state while high
//   opcode [OPC_W]              instruction opcode used by DISPATCH
//   flags  [FLAG_W]             condition flags used by BR_T / BR_F
//   us_we/us_waddr/us_wdata     microstore write port
//   dt_we/dt_waddr/dt_wdata     dispatch-table write port (MSB = valid)
//   signals [SIG_W]             signals field of the current microword
//   upc     [UADDR_W]           address of the current microword
//   err     [2]                 sticky: bit0 stack over/underflow, bit1 unmapped opcode
//
// Microword layout (MSB first): next_addr, fsel, seq_op[3], signals.
module micro_sequencer #(
    parameter  int UADDR_W     = 6,
    parameter  int SIG_W       = 24,
    parameter  int OPC_W       = 5,
    parameter  int FLAG_W      = 8,
    parameter  int FSEL_W      = 3,
    parameter  int STACK_DEPTH = 4,
    localparam int WORD_W      = UADDR_W + FSEL_W + 3 + SIG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic [OPC_W-1:0]   opcode,
    input  logic [FLAG_W-1:0]  flags,
    input  logic               us_we,
    input  logic [UADDR_W-1:0] us_waddr,
    input  logic [WORD_W-1:0]  us_wdata,
    input  logic               dt_we,
    input  logic [OPC_W-1:0]   dt_waddr,
    input  logic [UADDR_W:0]   dt_wdata,
    output logic [SIG_W-1:0]   signals,
    output logic [UADDR_W-1:0] upc,
    output logic [1:0]         err
);

    localparam int STORE_D = 2 ** UADDR_W;
    localparam int DT_D    = 2 ** OPC_W;
    localparam int FLAG_X  = 2 ** FSEL_W;
    localparam int SP_W    = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        OP_NEXT     = 3'b000,
        OP_DISPATCH = 3'b001,
        OP_BR_T     = 3'b010,
        OP_BR_F     = 3'b011,
        OP_CALL     = 3'b100,
        OP_RET      = 3'b101,
        OP_SEQ      = 3'b110,
        OP_RSVD     = 3'b111
    } seq_op_e;

    logic [WORD_W-1:0]  store [STORE_D];
    logic [UADDR_W:0]   dtab  [DT_D];
    logic [UADDR_W-1:0] stack [STACK_DEPTH];

    logic [WORD_W-1:0]  cur;
    logic [UADDR_W-1:0] upc_q;
    logic [SP_W-1:0]    sp;
    logic [1:0]         err_q;

    logic [UADDR_W-1:0] cur_next_addr;
    logic [FSEL_W-1:0]  cur_fsel;
    seq_op_e            cur_op;
    logic [FLAG_X-1:0]  flags_ext;
    logic               flag_bit;
    logic [UADDR_W:0]   dt_ent;
    logic [UADDR_W-1:0] upc_inc;
    logic [UADDR_W-1:0] nxt;
    logic               push;
    logic               pop;
    logic [1:0]         err_set;
    logic [IDX_W-1:0]   push_idx;
    logic [IDX_W-1:0]   pop_idx;

    assign cur_next_addr = cur[WORD_W-1 -: UADDR_W];
    assign cur_fsel      = cur[SIG_W+3 +: FSEL_W];
    assign cur_op        = seq_op_e'(cur[SIG_W +: 3]);

    // Zero-extending flags to the full fsel range makes any fsel >= FLAG_W read 0.
    assign flags_ext = FLAG_X'(flags);
    assign flag_bit  = flags_ext[cur_fsel];

    assign dt_ent   = dtab[opcode];
    assign upc_inc  = upc_q + 1'b1;
    assign push_idx = IDX_W'(sp);
    assign pop_idx  = IDX_W'(sp - 1'b1);

    always_comb begin
        nxt     = cur_next_addr;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = '0;
        case (cur_op)
            OP_NEXT, OP_RSVD: nxt = cur_next_addr;
            OP_DISPATCH: begin
                if (dt_ent[UADDR_W]) begin
                    nxt = dt_ent[UADDR_W-1:0];
                end else begin
                    nxt        = '0;
                    err_set[1] = 1'b1;
                end
            end
            OP_BR_T: nxt = flag_bit ? cur_next_addr : upc_inc;
            OP_BR_F: nxt = flag_bit ? upc_inc : cur_next_addr;
            OP_CALL: begin
                // A full stack drops the return address but still jumps.
                nxt = cur_next_addr;
                if (sp == SP_FULL) begin
                    err_set[0] = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end
            OP_RET: begin
                if (sp == '0) begin
                    nxt        = '0;
                    err_set[0] = 1'b1;
                end else begin
                    pop = 1'b1;
                    nxt = stack[pop_idx];
                end
            end
            OP_SEQ:  nxt = upc_inc;
            default: nxt = cur_next_addr;
        endcase
    end

    // Sequencer state: reset wins over everything, stall freezes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur   <= '0;
            upc_q <= '0;
            sp    <= '0;
            err_q <= '0;
        end else if (!stall) begin
            cur   <= store[nxt];
            upc_q <= nxt;
            err_q <= err_q | err_set;
            if (push) begin
                sp <= sp + 1'b1;
            end else if (pop) begin
                sp <= sp - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !stall && push) begin
            stack[push_idx] <= upc_inc;
        end
    end

    // Write ports ignore rst and stall; the fetch above reads pre-edge contents.
    always_ff @(posedge clk) begin
        if (us_we) begin
            store[us_waddr] <= us_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (dt_we) begin
            dtab[dt_waddr] <= dt_wdata;
        end
    end

    assign signals = cur[SIG_W-1:0];
    assign upc     = upc_q;
    assign err     = err_q;

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter UADDR_W, default 6: micro-address width; store depth is 2**UADDR_W.
REQ-002 Parameter SIG_W, default 24: control-signal field width.
REQ-003 Parameter OPC_W, default 5: opcode width; dispatch table depth is 2**OPC_W.
REQ-004 Parameter FLAG_W, default 8: flag vector width.
REQ-005 Parameter FSEL_W, default 3: flag-select field width; FLAG_W SHALL be at most 2**FSEL_W.
REQ-006 Parameter STACK_DEPTH, default 4: micro-return stack entries, minimum 1.
REQ-007 Derived width WORD_W = UADDR_W+FSEL_W+3+SIG_W; word layout from MSB is next_addr[UADDR_W], fsel[FSEL_W], seq_op[3], signals[SIG_W].
REQ-008 clk  in  1  clock; all state updates on the rising edge.
REQ-009 rst  in  1  reset, synchronous, active-high.
REQ-010 stall  in  1  when high, the sequencer holds all state.
REQ-011 opcode  in  OPC_W  current instruction opcode.
REQ-012 flags  in  FLAG_W  condition flags.
REQ-013 us_we / us_waddr / us_wdata  in  1 / UADDR_W / WORD_W  microstore write port.
REQ-014 dt_we / dt_waddr / dt_wdata  in  1 / OPC_W / UADDR_W+1  dispatch-table write port; dt_wdata MSB is the valid bit.
REQ-015 signals  out  SIG_W  signals field of the current microword.
REQ-016 upc  out  UADDR_W  address of the current microword.
REQ-017 err  out  2  sticky error flags: bit0 = stack over/underflow, bit1 = unmapped opcode.

Function
REQ-018 The block SHALL hold a registered current microword (cur) and its address (upc); signals and upc SHALL be driven directly from registers.
REQ-019 Each non-stalled cycle, the block SHALL compute next address nxt from cur.seq_op, then load cur <= store[nxt] and upc <= nxt (one-cycle latency from decision to signals).
REQ-020 seq_op 000 NEXT: nxt = next_addr.
REQ-021 seq_op 001 DISPATCH: nxt = dispatch[opcode] address if its valid bit is set; otherwise nxt = 0 and err[1] is set.
REQ-022 seq_op 010 BR_T: nxt = next_addr if flags[fsel] = 1, else upc+1.
REQ-023 seq_op 011 BR_F: nxt = next_addr if flags[fsel] = 0, else upc+1.
REQ-024 seq_op 100 CALL: push upc+1 and set nxt = next_addr; on a full stack, drop the push, set err[0], and still jump.
REQ-025 seq_op 101 RET: pop and set nxt = popped value; on an empty stack, set nxt = 0 and err[0].
REQ-026 seq_op 110 SEQ: nxt = upc+1; seq_op 111 is reserved and SHALL behave as NEXT.
REQ-027 upc+1 SHALL wrap modulo 2**UADDR_W (the last address goes to 0).
REQ-028 An fsel value of FLAG_W or greater SHALL read the flag as 0.
REQ-029 While stall is high: cur, upc, stack, and err SHALL hold, and signals SHALL stay constant; write ports remain active.
REQ-030 Microstore and dispatch writes SHALL take effect at the edge; a same-cycle fetch from the address being written SHALL return the old contents.
REQ-031 The stack SHALL be LIFO with pointer range 0..STACK_DEPTH; at most one push or pop per cycle.

Reset
REQ-032 On rst, cur SHALL be all-zero (signals = 0, NEXT to 0), upc = 0, stack pointer = 0, err = 0, regardless of stall or the operation in progress.
REQ-033 rst SHALL NOT clear microstore or dispatch-table contents.
REQ-034 The first non-stalled cycle after reset SHALL fetch address 0.
REQ-035 rst SHALL have priority over the write ports in the same cycle only for sequencer state; writes issued in the reset cycle SHALL still complete.

Verification
REQ-036 Set store[0] = DISPATCH, dispatch[5'b00111] = valid/addr 2, opcode = 00111 -> after reset, the second edge gives upc = 2 and signals = store[2].signals.
REQ-037 Set store[3] = BR_T fsel = 0, next_addr = 9: with flags[0] = 1 -> upc = 9; with flags[0] = 0 -> upc = 4.
REQ-038 Run nested CALLs to depth STACK_DEPTH, then the matching RETs -> each RET returns to its caller address+1 and err = 00.
REQ-039 Issue CALL at depth STACK_DEPTH -> err[0] = 1 and the jump is taken; RET on an empty stack -> upc = 0; err stays set until rst.
REQ-040 DISPATCH on an opcode whose dispatch entry is invalid -> upc = 0 and err[1] = 1.
REQ-041 Hold stall high for 3 cycles mid-sequence -> upc and signals are unchanged; assert rst during stall -> upc = 0, signals = 0, err = 00.
